// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU front end.
// Word-address and instruction widths, default reset PC, and the prefetch entry type.
package cpu_pkg;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO of {pc, instr} with synchronous flush.
// DEPTH is a power of two, so the pointers wrap naturally at their width.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    output fetch_entry_t           head_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LW'(push_i) - LW'(pop_i);
        end
    end

    // Storage needs no reset: the level gates everything read from it.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, prefetch FIFO,
// and redirect handling so decode only sees in-order, non-stale instructions.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                   Clk,
    input  logic                   Rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_W-1:0]      imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_W-1:0]     imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INSTR_W-1:0]     id_instr,
    output logic [ADDR_W-1:0]      id_pc,
    output logic [ADDR_W-1:0]      id_next_pc,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              outstanding_q, outstanding_d;
    logic              drop_q, drop_d;

    logic              req_fire, rsp_ok, push, pop, empty;
    logic [LW:0]       occupancy;
    fetch_entry_t      head, push_entry;

    // Outstanding request counts against capacity so its response always has a slot.
    assign occupancy      = {1'b0, fifo_level} + (LW+1)'(outstanding_q);
    assign imem_req_valid = !Rst && (!outstanding_q || imem_rsp_valid)
                            && (occupancy < (LW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_ok   = imem_rsp_valid && outstanding_q;
    assign push     = rsp_ok && !drop_q && !redirect_valid;
    assign pop      = !empty && id_ready && !redirect_valid;

    assign push_entry = '{pc: req_pc_q, instr: imem_rsp_data};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (req_fire) begin
            fetch_pc_d    = fetch_pc_q + 1'b1;
            req_pc_d      = fetch_pc_q;
            outstanding_d = 1'b1;
        end else if (rsp_ok) begin
            outstanding_d = 1'b0;
        end
        if (rsp_ok) drop_d = 1'b0;
        // Whatever is still in flight after a redirect belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            drop_d     = outstanding_d;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (empty),
        .level_o     (fifo_level)
    );

    assign id_valid   = !empty;
    assign id_instr   = empty ? '0 : head.instr;
    assign id_pc      = empty ? '0 : head.pc;
    assign id_next_pc = id_pc + 1'b1;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-configurable memory model plus an in-order
// PC stream reference (sequential from last redirect/reset) checked at every pop.
module tb_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RPC   = 16'h0000;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        imem_req_valid, imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [15:0] id_instr, id_pc, id_next_pc;
    logic [2:0]  fifo_level;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .Clk(Clk), .Rst(Rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_next_pc(id_next_pc),
        .fifo_level(fifo_level)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // memory model
    logic        mem_pending;
    logic [15:0] mem_addr;
    int          mem_cnt;
    int          fixed_lat;
    bit          rand_lat;

    // reference model and per-cycle samples
    logic [15:0] exp_pc;
    logic        s_req_valid, s_fire, s_id_valid, s_pop;
    logic [15:0] s_req_addr, s_id_pc, s_id_next;
    logic [2:0]  s_level;
    int          npops, nfires;
    bit          fp_seen, wrap_seen, wrap_req_seen;
    logic [15:0] fp_pc, last_fire_addr;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit rsp;
        int lat;
        rsp = mem_pending && (mem_cnt == 0);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memf(mem_addr) : 16'($urandom);
        #2;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_fire      = imem_req_valid && imem_req_ready;
        s_id_valid  = id_valid;
        s_id_pc     = id_pc;
        s_id_next   = id_next_pc;
        s_pop       = id_valid && id_ready;
        s_level     = fifo_level;
        if (s_pop && !redirect_valid) begin
            chk("pop_pc", id_pc, exp_pc);
            chk("pop_instr", id_instr, memf(exp_pc));
            chk("pop_next_pc", id_next_pc, exp_pc + 16'd1);
            npops++;
            if (!fp_seen) begin fp_seen = 1; fp_pc = id_pc; end
            if (id_pc == 16'hFFFF) wrap_seen = 1;
        end
        if (s_fire) begin
            chk("single_outstanding", 16'(mem_pending && !rsp), 16'd0);
            nfires++;
            if (s_req_addr == 16'h0000 && last_fire_addr == 16'hFFFF) wrap_req_seen = 1;
            last_fire_addr = s_req_addr;
        end
        @(posedge Clk);
        if (rsp) mem_pending = 0;
        else if (mem_pending) mem_cnt--;
        if (s_fire) begin
            lat = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
            mem_pending = 1;
            mem_addr    = s_req_addr;
            mem_cnt     = lat - 1;
        end
        if (redirect_valid) exp_pc = redirect_pc;
        else if (s_pop)     exp_pc = exp_pc + 16'd1;
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 16'(imem_req_valid), 16'd0);
        chk({tag, "_id_valid"}, 16'(id_valid), 16'd0);
        chk({tag, "_id_instr"}, id_instr, 16'h0000);
        chk({tag, "_id_pc"}, id_pc, 16'h0000);
        chk({tag, "_id_next_pc"}, id_next_pc, 16'h0001);
        chk({tag, "_level"}, 16'(fifo_level), 16'd0);
    endtask

    initial begin
        logic        found;
        logic [15:0] fa, rpc;
        Rst = 1; imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; id_ready = 0;
        mem_pending = 0; mem_addr = 0; mem_cnt = 0; fixed_lat = 1; rand_lat = 0;
        exp_pc = RPC; npops = 0; nfires = 0; fp_seen = 0; fp_pc = 0;
        wrap_seen = 0; wrap_req_seen = 0; last_fire_addr = 0;
        repeat (2) @(posedge Clk);
        #1;
        chk_reset_outputs("rst");

        // bring-up: 1-cycle memory, decode draining
        Rst = 0; id_ready = 1; exp_pc = RPC;
        cycle();
        chk("c1_req_valid", 16'(s_req_valid), 16'd1);
        chk("c1_req_addr", s_req_addr, RPC);
        cycle();
        chk("c2_id_valid", 16'(s_id_valid), 16'd0);
        chk("c2_req_addr", s_req_addr, RPC + 16'd1);
        cycle();
        chk("c3_id_valid", 16'(s_id_valid), 16'd1);
        chk("c3_id_pc", s_id_pc, RPC);
        chk("c3_id_next_pc", s_id_next, RPC + 16'd1);
        npops = 0;
        repeat (10) cycle();
        chk("throughput", 16'(npops), 16'd10);

        // decode stall fills the FIFO and throttles requests
        id_ready = 0;
        repeat (8) cycle();
        chk("stall_level", 16'(s_level), 16'(DEPTH));
        chk("stall_req_valid", 16'(s_req_valid), 16'd0);
        id_ready = 1; npops = 0; nfires = 0;
        repeat (6) cycle();
        chk("drain_pops", 16'(npops >= 4), 16'd1);
        chk("fetch_resumes", 16'(nfires > 0), 16'd1);

        // redirect while request to 0x0005 outstanding, 3-cycle memory
        fixed_lat = 3;
        redirect_valid = 1; redirect_pc = 16'h0003;
        cycle();
        redirect_valid = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = s_fire && (s_req_addr == 16'h0005);
        end
        chk("req5_seen", 16'(found), 16'd1);
        redirect_valid = 1; redirect_pc = 16'h0040; fp_seen = 0;
        cycle();
        redirect_valid = 0;
        cycle();
        chk("redir_level0", 16'(s_level), 16'd0);
        found = s_fire; fa = s_req_addr;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = s_fire; fa = s_req_addr;
        end
        chk("redir_first_req", fa, 16'h0040);
        for (int i = 0; i < 20 && !fp_seen; i++) cycle();
        chk("redir_first_pop", fp_pc, 16'h0040);

        // redirect coincident with response and pop
        fixed_lat = 1;
        repeat (6) cycle();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_pending && mem_cnt == 0 && id_valid) begin
                found = 1;
                rpc = 16'($urandom);
                redirect_valid = 1; redirect_pc = rpc; fp_seen = 0;
            end
            cycle();
            redirect_valid = 0;
        end
        chk("coinc_found", 16'(found), 16'd1);
        cycle();
        chk("coinc_level0", 16'(s_level), 16'd0);
        for (int i = 0; i < 20 && !fp_seen; i++) cycle();
        chk("coinc_first_pop", fp_pc, rpc);

        // PC wrap
        redirect_valid = 1; redirect_pc = 16'hFFFE; wrap_seen = 0; wrap_req_seen = 0;
        cycle();
        redirect_valid = 0;
        repeat (10) cycle();
        chk("wrap_pop_seen", 16'(wrap_seen), 16'd1);
        chk("wrap_req_seen", 16'(wrap_req_seen), 16'd1);

        // random traffic
        rand_lat = 1; npops = 0;
        repeat (400) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 16'($urandom);
            cycle();
        end
        redirect_valid = 0; imem_req_ready = 1; id_ready = 1; rand_lat = 0;
        chk("rand_pops", 16'(npops > 50), 16'd1);

        // reset with level 3 and a request outstanding
        fixed_lat = 3; id_ready = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = (fifo_level == 3'd3) && mem_pending;
        end
        chk("midrst_setup", 16'(found), 16'd1);
        Rst = 1;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge Clk);
        #1;
        mem_cnt = 0;
        Rst = 0; id_ready = 1; exp_pc = RPC; fp_seen = 0;
        cycle();
        chk("midrst_req_valid", 16'(s_req_valid), 16'd1);
        chk("midrst_req_addr", s_req_addr, RPC);
        for (int i = 0; i < 20 && !fp_seen; i++) cycle();
        chk("midrst_first_pop", fp_pc, RPC);
        repeat (6) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
